fasm_fifo_arb: RTL
==================

Name: fasm_fifo_arb

Overview:
- Round-robin write arbiter that shares the single write port of a fasm_fifo instance between NR requesters.
- Grants one requester at a time and holds the grant for a burst of up to BL words.
- Respects the FIFO full flag (fifo wok_o).
- Sits between multiple producer engines and one FIFO write port (dat_i/wre_i/wok_o).

Parameters:
- DW, 32, data word width; must match the FIFO DW.
- NR, 4, number of requesters; legal range 2..8.
- BL, 4, maximum words per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk_i  in  1  global clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- clr_i  in  1  synchronous clear, active-high; same effect as reset.
- ena_i  in  1  clock enable; when 0, all state frozen and no writes.
- req_i  in  NR  per-requester request; level, held while a word is offered.
- dat_i  in  NR*DW  requester data; requester k uses bits [k*DW+DW-1 : k*DW].
- ack_o  out  NR  per-requester word-accepted strobe, one-hot or zero.
- gnt_o  out  NR  current grant, one-hot or zero; registered.
- fdat_o  out  DW  data to FIFO dat_i.
- fwre_o  out  1  write strobe to FIFO wre_i.
- fwok_i  in  1  FIFO not-full (FIFO wok_o).

Behaviour:
- State: st (IDLE/GRANT), gnt (NR one-hot), last (index of last granted, log2 NR bits), cnt (8 bits).
- Reset (rst_i=0, async) or clr_i=1 at a clock edge:
  - st=IDLE, gnt_o=0, last=NR-1 (so requester 0 has first priority), cnt=0.
  - ack_o=0 and fwre_o=0 follow combinationally.
- clr_i has priority over ena_i.
- ena_i=0: no register updates; fwre_o=0, ack_o=0.
- IDLE, ena_i=1:
  - If any req_i bit is set and fwok_i=1: winner = first set bit scanning last+1, last+2, ... modulo NR.
  - Next: gnt_o=one-hot(winner), cnt=0, st=GRANT.
  - Otherwise remain in IDLE.
  - No write is issued in IDLE; the arbitration cycle costs one clock.
- GRANT, granted index g. Combinational:
  - wr = ena_i & req_i[g] & fwok_i.
  - fwre_o = wr.
  - ack_o[g] = wr.
  - fdat_o = dat_i slice g, always muxed by gnt_o; 0 when gnt_o=0.
- GRANT transitions, in priority order:
  - req_i[g]=0: release with no write; st=IDLE, gnt_o=0, last=g.
  - wr=1 and cnt=BL-1: final burst word written; release, st=IDLE, gnt_o=0, last=g.
  - wr=1 otherwise: cnt=cnt+1, stay in GRANT.
  - fwok_i=0 with req_i[g]=1: stall; hold grant, cnt unchanged, no write.
- Requester contract:
  - A word is consumed exactly on a cycle where ack_o[k]=1.
  - The requester presents its next word (or drops req) at the following edge.
  - Non-granted requesters see ack_o=0 and must hold their request.
- Fairness: after a release, the released index has lowest priority. A sole continuous requester is regranted after a one-cycle IDLE bubble, giving throughput BL/(BL+1).
- Latency: req_i rise in IDLE -> gnt_o at the next edge -> first fwre_o in that same following cycle (1-clock latency).
- The arbiter never writes while fwok_i=0, so it cannot overflow the FIFO.
- Reset mid-burst: grant is dropped immediately (async); the partial burst is lost from the arbiter's view, and words already acked are in the FIFO.
- Simultaneous FIFO read on a full FIFO: fwok_i rises one cycle later (FIFO registered flag); the arbiter resumes the write that cycle.

Test Plan:
- Reset and priority: release rst_i with req_i=4'b1111, fwok_i=1, BL=4. Required: gnt_o=0001 after 1 clk; ack_o[0] for 4 cycles, words D0..D3 written in order; then one IDLE cycle; then gnt_o=0010.
- Round-robin rotation: all four requesting continuously for 20 cycles. Required: grant order 0,1,2,3,0.
- Early release and hold-off: req_i=0010 with 2 words only, req_i[1] dropped after the second ack. Required: exactly 2 fwre_o pulses, release on the drop cycle, last=1; a new req_i=0011 grants 0 before 1.
- Full stall: granted requester 2, fwok_i forced 0 for 5 cycles mid-burst after 1 word. Required: fwre_o=0 and ack_o=0 during the stall, gnt_o held at 0100, cnt held at 1; after fwok_i=1 the remaining 3 words are written and then released.
- ena_i and clr_i:
  - ena_i=0 for 3 cycles mid-burst: state, cnt and grant frozen, no writes.
  - clr_i=1 during GRANT: gnt_o=0 next edge, and the next arbitration grants requester 0 first.
- Async reset mid-burst: assert rst_i between clock edges. Required: gnt_o=0, fwre_o=0, ack_o=0 immediately without a clock edge.

Source files
------------

// File: rtl/fasm_fifo_arb_if.sv
// Handshake bundle between NR producer engines, the write arbiter and one FIFO write port.
// Purely structural; carries no state and adds no latency.
// Backpressure comes in on fwok_i (FIFO not-full) and goes back out as ack_o.
interface fasm_fifo_arb_if #(
  parameter int DW = 32,
  parameter int NR = 4
);
  logic [NR-1:0]    req_i;
  logic [NR*DW-1:0] dat_i;
  logic [NR-1:0]    ack_o;
  logic [NR-1:0]    gnt_o;
  logic [DW-1:0]    fdat_o;
  logic             fwre_o;
  logic             fwok_i;

  // Producer/FIFO side: drives requests, data and the FIFO not-full flag
  modport master (
    output req_i, dat_i, fwok_i,
    input  ack_o, gnt_o, fdat_o, fwre_o
  );

  // Arbiter side
  modport slave (
    input  req_i, dat_i, fwok_i,
    output ack_o, gnt_o, fdat_o, fwre_o
  );
endinterface

// File: rtl/fasm_fifo_arb.sv
// Round-robin arbiter sharing one FIFO write port among NR requesters, in bursts of up to BL words.
// Latency: one clock from a request in IDLE to the grant; the first write happens in the granted cycle.
// Backpressure: no write while fwok_i=0; the grant and burst count hold until the FIFO has room.
module fasm_fifo_arb #(
  parameter int DW = 32,
  parameter int NR = 4,
  parameter int BL = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           ena_i,
  fasm_fifo_arb_if.slave bus
);

  localparam int LW = $clog2(NR);
  localparam logic [7:0]    CNT_LAST = 8'(BL - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NR - 1);

  typedef enum logic {IDLE, GRANT} st_t;

  st_t           st_q, st_d;
  logic [NR-1:0] gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [LW-1:0] g_idx;
  logic [LW-1:0] win_idx;
  logic          win_vld;
  int            scan_idx;
  logic          wr;
  logic [DW-1:0] fdat;

  // Decode the one-hot grant into the index of the granted requester
  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NR; k++) begin
      if (gnt_q[LW'(k)]) g_idx = LW'(k);
    end
  end

  // Round-robin pick: first requester found scanning from last+1 upwards, wrapping at NR
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int i = 1; i <= NR; i++) begin
      scan_idx = (int'(last_q) + i) % NR;
      if (!win_vld && bus.req_i[LW'(scan_idx)]) begin
        win_vld = 1'b1;
        win_idx = LW'(scan_idx);
      end
    end
  end

  // Data mux driven by the registered grant; all-zero when nobody holds the grant
  always_comb begin
    fdat = '0;
    for (int k = 0; k < NR; k++) begin
      if (gnt_q[LW'(k)]) fdat = fdat | bus.dat_i[k*DW +: DW];
    end
  end

  assign wr = ena_i & (st_q == GRANT) & bus.req_i[g_idx] & bus.fwok_i;

  assign bus.fwre_o = wr;
  assign bus.ack_o  = wr ? gnt_q : '0;
  assign bus.gnt_o  = gnt_q;
  assign bus.fdat_o = fdat;

  // Next-state: arbitration in IDLE, burst counting, release and stall in GRANT
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      st_d   = IDLE;
      gnt_d  = '0;
      last_d = LAST_RST;
      cnt_d  = '0;
    end else if (ena_i) begin
      case (st_q)
        IDLE: begin
          if (win_vld && bus.fwok_i) begin
            gnt_d = NR'(1) << win_idx;
            cnt_d = '0;
            st_d  = GRANT;
          end
        end
        GRANT: begin
          if (!bus.req_i[g_idx]) begin
            // Requester withdrew: give the port back without writing
            st_d   = IDLE;
            gnt_d  = '0;
            last_d = g_idx;
          end else if (wr && (cnt_q == CNT_LAST)) begin
            // Last word of the burst: force re-arbitration
            st_d   = IDLE;
            gnt_d  = '0;
            last_d = g_idx;
          end else if (wr) begin
            cnt_d = cnt_q + 8'd1;
          end
          // FIFO full with request still up: hold everything
        end
        default: begin
          st_d  = IDLE;
          gnt_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      last_q <= LAST_RST;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
